// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: turns a simple valid/ready command into a single AXI4-Lite
// read or write and returns the response. Only one transaction is outstanding at a time.
// Optional feature: define TIMEOUT_EN to abort transactions that exceed TimeoutCycles_Gen
// cycles from command acceptance (RspStatus 2'b10, RspData 32'hDEADBEEF).
module axi_lite_cmd_master #(
  parameter int unsigned TimeoutCycles_Gen = 1024
) (
  input  logic        SysClk_ClkIn,
  input  logic        SysRstN_RstIn,
  // command side
  input  logic        CmdValid_ValIn,
  output logic        CmdReady_RdyOut,
  input  logic        CmdWrite_DatIn,
  input  logic [15:0] CmdAddress_AdrIn,
  input  logic [31:0] CmdData_DatIn,
  input  logic [3:0]  CmdStrobe_DatIn,
  // response side
  output logic        RspValid_ValOut,
  input  logic        RspReady_RdyIn,
  output logic [31:0] RspData_DatOut,
  output logic [1:0]  RspStatus_DatOut,
  // AXI4-Lite master
  output logic        AxiWriteAddrValid_ValOut,
  input  logic        AxiWriteAddrReady_RdyIn,
  output logic [15:0] AxiWriteAddrAddress_AdrOut,
  output logic        AxiWriteDataValid_ValOut,
  input  logic        AxiWriteDataReady_RdyIn,
  output logic [31:0] AxiWriteDataData_DatOut,
  output logic [3:0]  AxiWriteDataStrobe_DatOut,
  input  logic        AxiWriteRespValid_ValIn,
  output logic        AxiWriteRespReady_RdyOut,
  input  logic [1:0]  AxiWriteRespResponse_DatIn,
  output logic        AxiReadAddrValid_ValOut,
  input  logic        AxiReadAddrReady_RdyIn,
  output logic [15:0] AxiReadAddrAddress_AdrOut,
  input  logic        AxiReadDataValid_ValIn,
  output logic        AxiReadDataReady_RdyOut,
  input  logic [1:0]  AxiReadDataResponse_DatIn,
  input  logic [31:0] AxiReadDataData_DatIn
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWaddr = 3'd1,
    StWresp = 3'd2,
    StRaddr = 3'd3,
    StRresp = 3'd4,
    StRsp   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic        accept;
  logic        aw_done, w_done;

  assign accept  = (state_q == StIdle) && cmd_ready_q && CmdValid_ValIn;
  // An address/data channel counts as done if it already handshook or does so this edge.
  assign aw_done = !awvalid_q || AxiWriteAddrReady_RdyIn;
  assign w_done  = !wvalid_q || AxiWriteDataReady_RdyIn;

`ifdef TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles_Gen + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy, busy_next;

  assign busy      = state_q inside {StWaddr, StWresp, StRaddr, StRresp};
  assign busy_next = state_d inside {StWaddr, StWresp, StRaddr, StRresp};

  // Transaction age counter, cleared on acceptance.
  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles_Gen;
`endif

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    rsp_valid_d  = rsp_valid_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;

    case (state_q)
      StIdle: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          addr_d      = CmdAddress_AdrIn;
          wdata_d     = CmdData_DatIn;
          strb_d      = CmdStrobe_DatIn;
          if (CmdWrite_DatIn) begin
            state_d   = StWaddr;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = StRaddr;
            arvalid_d = 1'b1;
          end
        end
      end
      StWaddr: begin
        if (awvalid_q && AxiWriteAddrReady_RdyIn) awvalid_d = 1'b0;
        if (wvalid_q && AxiWriteDataReady_RdyIn) wvalid_d = 1'b0;
        if (aw_done && w_done) begin
          state_d  = StWresp;
          bready_d = 1'b1;
        end
      end
      StWresp: begin
        if (AxiWriteRespValid_ValIn) begin
          state_d      = StRsp;
          bready_d     = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = 32'h0;
          rsp_status_d = AxiWriteRespResponse_DatIn;
        end
      end
      StRaddr: begin
        if (AxiReadAddrReady_RdyIn) begin
          state_d   = StRresp;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      StRresp: begin
        if (AxiReadDataValid_ValIn) begin
          state_d      = StRsp;
          rready_d     = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = AxiReadDataData_DatIn;
          rsp_status_d = AxiReadDataResponse_DatIn;
        end
      end
      StRsp: begin
        if (RspReady_RdyIn) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef TIMEOUT_EN
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + CntW'(1);
    end
    // Abort only if this edge does not already complete the B/R handshake.
    if (busy && busy_next && (cnt_q == CntW'(TimeoutCycles_Gen - 1))) begin
      state_d      = StRsp;
      awvalid_d    = 1'b0;
      wvalid_d     = 1'b0;
      bready_d     = 1'b0;
      arvalid_d    = 1'b0;
      rready_d     = 1'b0;
      rsp_valid_d  = 1'b1;
      rsp_status_d = 2'b10;
      rsp_data_d   = 32'hDEADBEEF;
    end
`endif
  end

  // State and registered-output flops.
  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      state_q      <= StIdle;
      cmd_ready_q  <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      addr_q       <= 16'h0;
      wdata_q      <= 32'h0;
      strb_q       <= 4'h0;
      rsp_data_q   <= 32'h0;
      rsp_status_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      rsp_valid_q  <= rsp_valid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign CmdReady_RdyOut            = cmd_ready_q;
  assign RspValid_ValOut            = rsp_valid_q;
  assign RspData_DatOut             = rsp_data_q;
  assign RspStatus_DatOut           = rsp_status_q;
  assign AxiWriteAddrValid_ValOut   = awvalid_q;
  assign AxiWriteAddrAddress_AdrOut = addr_q;
  assign AxiWriteDataValid_ValOut   = wvalid_q;
  assign AxiWriteDataData_DatOut    = wdata_q;
  assign AxiWriteDataStrobe_DatOut  = strb_q;
  assign AxiWriteRespReady_RdyOut   = bready_q;
  assign AxiReadAddrValid_ValOut    = arvalid_q;
  assign AxiReadAddrAddress_AdrOut  = addr_q;
  assign AxiReadDataReady_RdyOut    = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master: drives commands, plays an AXI4-Lite slave with configurable
// delays, and compares responses against a word-addressed memory model.
module tb_axi_lite_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [3:0]  cmd_strobe = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        aw_valid, aw_ready = 1'b0, w_valid, w_ready = 1'b0;
  logic [15:0] aw_addr, ar_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strobe;
  logic        b_valid = 1'b0, b_ready;
  logic [1:0]  b_resp = '0, r_resp = '0;
  logic        ar_valid, ar_ready = 1'b0, r_valid = 1'b0, r_ready;
  logic [31:0] r_data = '0;
  wire  [40:0] all_outs = {cmd_ready, rsp_valid, rsp_data, rsp_status, aw_valid, w_valid,
                           b_ready, ar_valid, r_ready};

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model_mem [0:16383];
  logic [31:0] slave_mem [0:16383];

  // Observations from the last drive_txn call
  int          obs_acc_wait, obs_aw_first, obs_aw_high, obs_w_first, obs_w_high;
  int          obs_ar_first, obs_b_hs, obs_r_hs, obs_rsp_first, obs_rsp_high, obs_bad;
  bit          obs_done, obs_ready_after;
  logic [31:0] obs_rsp_data;
  logic [1:0]  obs_rsp_status;

  axi_lite_cmd_master #(.TimeoutCycles_Gen(16)) dut (
    .SysClk_ClkIn               (clk),
    .SysRstN_RstIn              (rst_n),
    .CmdValid_ValIn             (cmd_valid),
    .CmdReady_RdyOut            (cmd_ready),
    .CmdWrite_DatIn             (cmd_write),
    .CmdAddress_AdrIn           (cmd_addr),
    .CmdData_DatIn              (cmd_data),
    .CmdStrobe_DatIn            (cmd_strobe),
    .RspValid_ValOut            (rsp_valid),
    .RspReady_RdyIn             (rsp_ready),
    .RspData_DatOut             (rsp_data),
    .RspStatus_DatOut           (rsp_status),
    .AxiWriteAddrValid_ValOut   (aw_valid),
    .AxiWriteAddrReady_RdyIn    (aw_ready),
    .AxiWriteAddrAddress_AdrOut (aw_addr),
    .AxiWriteDataValid_ValOut   (w_valid),
    .AxiWriteDataReady_RdyIn    (w_ready),
    .AxiWriteDataData_DatOut    (w_data),
    .AxiWriteDataStrobe_DatOut  (w_strobe),
    .AxiWriteRespValid_ValIn    (b_valid),
    .AxiWriteRespReady_RdyOut   (b_ready),
    .AxiWriteRespResponse_DatIn (b_resp),
    .AxiReadAddrValid_ValOut    (ar_valid),
    .AxiReadAddrReady_RdyIn     (ar_ready),
    .AxiReadAddrAddress_AdrOut  (ar_addr),
    .AxiReadDataValid_ValIn     (r_valid),
    .AxiReadDataReady_RdyOut    (r_ready),
    .AxiReadDataResponse_DatIn  (r_resp),
    .AxiReadDataData_DatIn      (r_data)
  );

  always #5 clk = ~clk;

  // Issues one command and acts as the slave; called and left at a negedge.
  // addr_dly: cycles of AW/AR VALID before READY; w_dly likewise for W; b_dly/r_dly: cycles
  // after the address/data handshakes before B/R VALID; rsp_dly: cycles RspReady stays low.
  task automatic drive_txn(input bit wr, input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int addr_dly, input int w_dly,
                           input int b_dly, input int r_dly, input logic [1:0] resp,
                           input int rsp_dly, input int max_cyc);
    int b_wait = 0, r_wait = 0;
    bit aw_ok = 0, w_ok = 0, ar_ok = 0, b_ok = 0, r_ok = 0, mem_wr = 0, consumed = 0;
    logic [15:0] aw_a = '0, ar_a = '0;
    logic [31:0] w_d = '0;
    logic [3:0]  w_s = '0;
    obs_acc_wait = 0; obs_aw_first = -1; obs_aw_high = 0; obs_w_first = -1; obs_w_high = 0;
    obs_ar_first = -1; obs_b_hs = 0; obs_r_hs = 0; obs_rsp_first = -1; obs_rsp_high = 0;
    obs_bad = 0; obs_done = 0; obs_ready_after = 0; obs_rsp_data = 'x; obs_rsp_status = 'x;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d; cmd_strobe = s;
    while (cmd_ready !== 1'b1 && obs_acc_wait < 20) begin
      @(negedge clk);
      obs_acc_wait++;
    end
    if (cmd_ready !== 1'b1) begin
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // Scramble the command bus so a design that fails to capture it gets caught.
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 16'($urandom);
    cmd_data = $urandom; cmd_strobe = 4'($urandom);
    for (int cyc = 1; cyc <= max_cyc && !obs_done; cyc++) begin
      if (consumed) begin
        obs_ready_after = (cmd_ready === 1'b1) && (rsp_valid === 1'b0);
        rsp_ready = 1'b0;
        obs_done = 1;
      end else begin
        if (aw_valid) begin
          if (obs_aw_first < 0) obs_aw_first = cyc;
          obs_aw_high++;
          if (aw_addr !== a || !wr) obs_bad++;
        end
        if (w_valid) begin
          if (obs_w_first < 0) obs_w_first = cyc;
          obs_w_high++;
          if (w_data !== d || w_strobe !== s || !wr) obs_bad++;
        end
        if (ar_valid) begin
          if (obs_ar_first < 0) obs_ar_first = cyc;
          if (ar_addr !== a || wr) obs_bad++;
        end
        if (b_ready && (!wr || aw_valid || w_valid || b_ok)) obs_bad++;
        if (r_ready && (wr || ar_valid || r_ok)) obs_bad++;
        if (cmd_ready) obs_bad++;
        if (rsp_valid) begin
          if (obs_rsp_first < 0) begin
            obs_rsp_first = cyc; obs_rsp_data = rsp_data; obs_rsp_status = rsp_status;
          end else if (rsp_data !== obs_rsp_data || rsp_status !== obs_rsp_status) begin
            obs_bad++;
          end
          obs_rsp_high++;
        end
        // Slave response channels use handshake state from earlier edges only.
        b_valid = wr && aw_ok && w_ok && !b_ok && (b_wait >= b_dly);
        r_valid = !wr && ar_ok && !r_ok && (r_wait >= r_dly);
        b_resp = resp; r_resp = resp;
        r_data = slave_mem[ar_a[15:2]];
        if (aw_ok && w_ok) b_wait++;
        if (ar_ok) r_wait++;
        aw_ready = aw_valid && (obs_aw_high > addr_dly);
        w_ready  = w_valid && (obs_w_high > w_dly);
        ar_ready = ar_valid && (cyc - obs_ar_first >= addr_dly);
        if (aw_valid && aw_ready) begin aw_ok = 1; aw_a = aw_addr; end
        if (w_valid && w_ready) begin w_ok = 1; w_d = w_data; w_s = w_strobe; end
        if (ar_valid && ar_ready) begin ar_ok = 1; ar_a = ar_addr; end
        if (b_valid && b_ready) begin b_ok = 1; obs_b_hs++; end
        if (r_valid && r_ready) begin r_ok = 1; obs_r_hs++; end
        if (aw_ok && w_ok && !mem_wr) begin
          for (int i = 0; i < 4; i++)
            if (w_s[i]) slave_mem[aw_a[15:2]][8*i +: 8] = w_d[8*i +: 8];
          mem_wr = 1;
        end
        rsp_ready = rsp_valid && (obs_rsp_high > rsp_dly);
        consumed = rsp_ready;
      end
      if (!obs_done) @(negedge clk);
    end
    aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0; rsp_ready = 0;
  endtask

  // Reference: a word memory with byte strobes; reads return the word, writes return 0.
  task automatic model_apply(input bit wr, input logic [15:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] exp_data);
    logic [31:0] word;
    word = model_mem[a[15:2]];
    if (wr) begin
      for (int i = 0; i < 4; i++) if (s[i]) word[8*i +: 8] = d[8*i +: 8];
      model_mem[a[15:2]] = word;
      exp_data = 32'h0;
    end else begin
      exp_data = word;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (all_outs !== 41'h0) begin
      n_fail++; $display("FAIL reset_outs: got %h want 0", all_outs);
    end
    rst_n = 1'b1;
    n_tests++;
    if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_before_edge: got %b want 0", cmd_ready);
    end
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_after_release: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write_basic();
    logic [31:0] exp;
    model_apply(1, 16'h0010, 32'h12345678, 4'hF, exp);
    drive_txn(1, 16'h0010, 32'h12345678, 4'hF, 0, 0, 0, 0, 2'b00, 0, 30);
    n_tests++;
    if (!obs_done) begin n_fail++; $display("FAIL wr_done: got 0 want 1"); end
    n_tests++;
    if (obs_aw_first !== 1 || obs_w_first !== 1) begin
      n_fail++; $display("FAIL wr_valid_lat: got aw %0d w %0d want 1 1", obs_aw_first, obs_w_first);
    end
    n_tests++;
    if (obs_rsp_first < 1 || obs_rsp_first > 4) begin
      n_fail++; $display("FAIL wr_rsp_lat: got %0d want 1..4", obs_rsp_first);
    end
    n_tests++;
    if (obs_rsp_data !== exp || obs_rsp_status !== 2'b00) begin
      n_fail++; $display("FAIL wr_rsp: got %h/%b want %h/00", obs_rsp_data, obs_rsp_status, exp);
    end
    n_tests++;
    if (obs_b_hs !== 1 || obs_bad !== 0) begin
      n_fail++; $display("FAIL wr_proto: got bhs %0d bad %0d want 1 0", obs_b_hs, obs_bad);
    end
  endtask

  task automatic test_read_basic();
    logic [31:0] exp;
    model_apply(0, 16'h0010, 32'h0, 4'h0, exp);
    drive_txn(0, 16'h0010, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 0, 30);
    n_tests++;
    if (obs_ar_first !== 1) begin
      n_fail++; $display("FAIL rd_ar_lat: got %0d want 1", obs_ar_first);
    end
    n_tests++;
    if (!obs_done || obs_rsp_data !== exp || obs_rsp_status !== 2'b00) begin
      n_fail++; $display("FAIL rd_rsp: got %h/%b want %h/00", obs_rsp_data, obs_rsp_status, exp);
    end
    n_tests++;
    if (obs_r_hs !== 1 || obs_bad !== 0 || !obs_ready_after) begin
      n_fail++; $display("FAIL rd_proto: got rhs %0d bad %0d after %0d want 1 0 1",
                         obs_r_hs, obs_bad, obs_ready_after);
    end
  endtask

  task automatic test_aw_delay();
    logic [31:0] exp;
    model_apply(1, 16'h0044, 32'hCAFEF00D, 4'h5, exp);
    drive_txn(1, 16'h0044, 32'hCAFEF00D, 4'h5, 3, 0, 1, 0, 2'b00, 0, 30);
    n_tests++;
    if (obs_w_high !== 1 || obs_aw_high !== 4) begin
      n_fail++; $display("FAIL aw_delay_valids: got w %0d aw %0d want 1 4", obs_w_high, obs_aw_high);
    end
    n_tests++;
    if (!obs_done || obs_b_hs !== 1 || obs_bad !== 0) begin
      n_fail++; $display("FAIL aw_delay_b: got done %0d bhs %0d bad %0d want 1 1 0",
                         obs_done, obs_b_hs, obs_bad);
    end
  endtask

  task automatic test_rsp_backpressure();
    logic [31:0] exp;
    model_apply(0, 16'h0044, 32'h0, 4'h0, exp);
    drive_txn(0, 16'h0044, 32'h0, 4'h0, 1, 0, 2, 2, 2'b01, 5, 40);
    n_tests++;
    if (obs_rsp_high !== 6) begin
      n_fail++; $display("FAIL bp_rsp_hold: got %0d want 6", obs_rsp_high);
    end
    n_tests++;
    if (obs_bad !== 0 || !obs_ready_after) begin
      n_fail++; $display("FAIL bp_stable: got bad %0d after %0d want 0 1", obs_bad, obs_ready_after);
    end
    n_tests++;
    if (obs_rsp_data !== exp || obs_rsp_status !== 2'b01) begin
      n_fail++; $display("FAIL bp_rsp: got %h/%b want %h/01", obs_rsp_data, obs_rsp_status, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) begin
      model_apply(i < 2, 16'h0080, 32'hA5A50000 + i, 4'(i + 3), exp);
      drive_txn(i < 2, 16'h0080, 32'hA5A50000 + i, 4'(i + 3), 0, 0, 0, 0, 2'b00, 0, 30);
      n_tests++;
      if (obs_acc_wait !== 0 || obs_rsp_data !== exp || obs_bad !== 0) begin
        n_fail++; $display("FAIL b2b_%0d: got wait %0d data %h bad %0d want 0 %h 0",
                           i, obs_acc_wait, obs_rsp_data, obs_bad, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp, d;
    logic [15:0] a;
    logic [3:0]  s;
    logic [1:0]  resp;
    bit          wr;
    for (int i = 0; i < 60; i++) begin
      wr = (i < 8) ? 1'b1 : 1'($urandom);
      a = 16'h0100 + 16'($urandom_range(0, 31));
      d = $urandom; s = 4'($urandom); resp = 2'($urandom);
      model_apply(wr, a, d, s, exp);
      drive_txn(wr, a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), resp, $urandom_range(0, 3), 60);
      n_tests++;
      if (!obs_done || obs_rsp_data !== exp || obs_rsp_status !== resp) begin
        n_fail++; $display("FAIL rand_%0d_rsp: got done %0d %h/%b want 1 %h/%b",
                           i, obs_done, obs_rsp_data, obs_rsp_status, exp, resp);
      end
      n_tests++;
      if (obs_bad !== 0 || !obs_ready_after || (obs_b_hs + obs_r_hs) !== 1) begin
        n_fail++; $display("FAIL rand_%0d_proto: got bad %0d after %0d hs %0d want 0 1 1",
                           i, obs_bad, obs_ready_after, obs_b_hs + obs_r_hs);
      end
    end
  endtask

  task automatic test_stall_and_reset();
`ifdef TIMEOUT_EN
    drive_txn(1, 16'h0020, 32'h11112222, 4'hF, 1000, 0, 0, 0, 2'b00, 0, 40);
    n_tests++;
    if (!obs_done || obs_rsp_first !== 17 || obs_aw_high !== 16) begin
      n_fail++; $display("FAIL timeout_timing: got done %0d rsp %0d aw %0d want 1 17 16",
                         obs_done, obs_rsp_first, obs_aw_high);
    end
    n_tests++;
    if (obs_rsp_status !== 2'b10 || obs_rsp_data !== 32'hDEADBEEF || obs_b_hs !== 0) begin
      n_fail++; $display("FAIL timeout_rsp: got %h/%b bhs %0d want deadbeef/10 0",
                         obs_rsp_data, obs_rsp_status, obs_b_hs);
    end
`else
    drive_txn(1, 16'h0020, 32'h11112222, 4'hF, 1000, 0, 0, 0, 2'b00, 0, 40);
    n_tests++;
    if (obs_done || obs_rsp_first !== -1 || obs_aw_high !== 40) begin
      n_fail++; $display("FAIL stall_wait: got done %0d rsp %0d aw %0d want 0 -1 40",
                         obs_done, obs_rsp_first, obs_aw_high);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (all_outs !== 41'h0) begin
      n_fail++; $display("FAIL stall_reset_outs: got %h want 0", all_outs);
    end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
`endif
    // Reset in the middle of a read that never gets its R beat.
    drive_txn(0, 16'h0030, 32'h0, 4'h0, 0, 0, 0, 1000, 2'b00, 0, 8);
    n_tests++;
    if (r_ready !== 1'b1 || obs_done) begin
      n_fail++; $display("FAIL rresp_wait: got rready %b done %0d want 1 0", r_ready, obs_done);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (all_outs !== 41'h0) begin
      n_fail++; $display("FAIL rresp_reset_outs: got %h want 0", all_outs);
    end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 16384; i++) begin
      v = $urandom; model_mem[i] = v; slave_mem[i] = v;
    end
    @(negedge clk);
    test_reset();
    test_write_basic();
    test_read_basic();
    test_aw_delay();
    test_rsp_backpressure();
    test_back_to_back();
    test_random();
    test_stall_and_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
